// File: rtl/streebog_l_transform.sv
// Streebog linear transform L, computed bit-serially over the 64 rows of the
// A-matrix ROM for LANES 64-bit words at once.
//
// Handshake: rdy=1 means the block is idle and dout holds the last result.
// A rising edge with rdy=1 and ena=1 starts an operation: din is captured on
// that edge and rdy drops. ena while rdy=0 is ignored. rdy returns high, and
// dout is updated, exactly 66 cycles after the start edge.

// ROM for the transform. Word k holds the contribution of every input bit to
// output bit k: bit (63-j) of word k is bit k of A row j. This matches the
// reference l(), where input bit 63 selects row 0 and input bit 0 selects row 63.
module streebog_rom_a_matrix (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [63:0] dout
);

    localparam logic [63:0] A_ROWS [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    logic [63:0] word;

    // Gather column addr of the A matrix into one ROM word.
    always_comb begin
        word = '0;
        for (int j = 0; j < 64; j++) begin
            word[63-j] = A_ROWS[j][addr];
        end
    end

    // Registered read: one cycle of latency, no reset needed for a ROM.
    always_ff @(posedge clk) begin
        dout <= word;
    end

endmodule

module streebog_l_transform #(
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    output logic                  rdy,
    input  logic [64*LANES-1:0]   din,
    output logic [64*LANES-1:0]   dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic [5:0]          addr;
    logic                addr_vld;   // addr holds a live ROM address this cycle
    logic                rom_vld;    // rom_dout holds a word to accumulate
    logic [63:0]         rom_dout;
    logic [64*LANES-1:0] x_reg;
    logic [64*LANES-1:0] y_reg;

    streebog_rom_a_matrix u_rom (
        .clk  (clk),
        .addr (addr),
        .dout (rom_dout)
    );

    // Control FSM: capture input, walk addresses 0..63, drain the ROM, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rdy      <= 1'b1;
            dout     <= '0;
            addr     <= '0;
            addr_vld <= 1'b0;
            rom_vld  <= 1'b0;
            x_reg    <= '0;
        end else begin
            rom_vld <= addr_vld;
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        x_reg    <= din;
                        addr     <= '0;
                        addr_vld <= 1'b1;
                        rdy      <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    addr <= addr + 6'd1;
                    // This edge issues address 63; stop counting, no wrap.
                    if (addr == 6'd62) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // First edge retires address 63 into the ROM; then wait
                    // for its word to be accumulated before publishing.
                    if (addr_vld) begin
                        addr_vld <= 1'b0;
                    end else if (!rom_vld) begin
                        dout  <= y_reg;
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-lane accumulator: shift in one output bit per ROM word, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
        end else if (rom_vld) begin
            for (int n = 0; n < LANES; n++) begin
                y_reg[64*n +: 64] <= {^(x_reg[64*n +: 64] & rom_dout), y_reg[64*n+1 +: 63]};
            end
        end
    end

endmodule

// File: tb/tb_streebog_l_transform.sv
// Bench for streebog_l_transform: random and directed operations checked
// against a reference l() model and a cycle-count model of rdy/dout.
module tb_streebog_l_transform;

    localparam int LANES = 8;
    localparam int W     = 64 * LANES;
    localparam int LAT   = 66;

    localparam logic [63:0] A_TBL [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         rdy;
    logic [W-1:0] din;
    logic [W-1:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    streebog_l_transform #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .rdy   (rdy),
        .din   (din),
        .dout  (dout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Reference l(): input bit (63-j) selects row j of A.
    function automatic logic [63:0] l_lane(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            if (x[63-j]) r = r ^ A_TBL[j];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] l_all(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int n = 0; n < LANES; n++) begin
            r[64*n +: 64] = l_lane(d[64*n +: 64]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) begin
            r[32*i +: 32] = $urandom();
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    // ---------------- scoreboard model of rdy / dout ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout;
    int           exp_busy;

    // Busy for LAT cycles after an accepted start; result appears on the last.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy = 0;
            exp_dout = '0;
            exp_q.delete();
        end else if (exp_busy == 0) begin
            if (ena === 1'b1) begin
                exp_q.push_back(l_all(din));
                exp_busy = LAT;
            end
        end else begin
            exp_busy = exp_busy - 1;
            if (exp_busy == 0 && exp_q.size() > 0) begin
                exp_dout = exp_q.pop_front();
            end
        end
    end

    // Every cycle: rdy must match the model; dout must match whenever rdy=1.
    always @(negedge clk) begin
        #1;
        check("cyc_rdy", W'(rdy), W'(exp_busy == 0));
        if (exp_busy == 0) begin
            check("cyc_dout", dout, exp_dout);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (rdy !== 1'b1) begin
            check("wait_idle_timeout", W'(rdy), W'(1));
        end
    endtask

    // Start one operation, optionally pulse ena at given busy cycles,
    // and return the result and the number of cycles rdy stayed low.
    task automatic run_op(input logic [W-1:0] d, input int p1, input int p2,
                          output logic [W-1:0] res, output int lat);
        @(negedge clk);
        wait_idle();
        din = d;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        din = rand_word();
        lat = 0;
        while (rdy !== 1'b1 && lat < 200) begin
            lat++;
            ena = (lat == p1 || lat == p2);
            @(negedge clk);
        end
        ena = 1'b0;
        res = dout;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] res, ra, rb, rab, a, b, d;
    logic [63:0]  msb, one;
    int           lat;

    initial begin
        msb   = 64'h8000000000000000;
        one   = 64'h1;
        rst_n = 1'b0;
        ena   = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        check("reset_rdy", W'(rdy), W'(1));
        check("reset_dout", dout, '0);
        rst_n = 1'b1;

        // Pin the model with hand values: A row 0 and row 63.
        check("model_row0", W'(l_lane(msb)), W'(64'h8E20FAA72BA0B470));
        check("model_row63", W'(l_lane(one)), W'(64'h641C314B2B8EE083));

        // 1. zero input
        run_op('0, -1, -1, res, lat);
        check("zero_latency", W'(lat), W'(LAT));
        check("zero_dout", res, '0);

        // 2. lane0 MSB only
        d = '0;
        d[63:0] = msb;
        run_op(d, -1, -1, res, lat);
        check("lane0_row0", res, W'(64'h8E20FAA72BA0B470));

        // 3. all lanes MSB
        run_op({LANES{msb}}, -1, -1, res, lat);
        check("all_row0", res, {LANES{64'h8E20FAA72BA0B470}});

        // lane7 LSB only -> A row 63 in lane7
        d = '0;
        d[W-1 -: 64] = one;
        run_op(d, -1, -1, res, lat);
        check("lane7_row63", res, {64'h641C314B2B8EE083, {(W-64){1'b0}}});

        // 4. linearity on random data
        for (int t = 0; t < 3; t++) begin
            a = rand_word();
            b = rand_word();
            run_op(a, -1, -1, ra, lat);
            check("lin_a", ra, l_all(a));
            run_op(b, -1, -1, rb, lat);
            check("lin_b", rb, l_all(b));
            run_op(a ^ b, -1, -1, rab, lat);
            check("lin_ab", rab, ra ^ rb);
        end

        // 5. spurious ena during a run
        a = rand_word();
        run_op(a, 10, 40, res, lat);
        check("extra_ena_latency", W'(lat), W'(LAT));
        check("extra_ena_dout", res, l_all(a));

        // back-to-back: ena raised the cycle rdy returns
        a = rand_word();
        run_op(a, -1, -1, res, lat);
        din = rand_word();
        b   = din;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        #1;
        check("b2b_accepted", W'(rdy), W'(0));
        wait_idle();
        check("b2b_dout", dout, l_all(b));

        // 6. reset at cycle 30 of a run
        @(negedge clk);
        din = rand_word();
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", W'(rdy), W'(1));
        check("midrst_dout", dout, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d = '0;
        d[63:0] = msb;
        run_op(d, -1, -1, res, lat);
        check("post_rst_latency", W'(lat), W'(LAT));
        check("post_rst_dout", res, W'(64'h8E20FAA72BA0B470));

        // random operations with some zeroed lanes
        for (int t = 0; t < 5; t++) begin
            a = rand_word();
            for (int n = 0; n < LANES; n++) begin
                if ($urandom_range(0, 3) == 0) a[64*n +: 64] = '0;
            end
            run_op(a, -1, $urandom_range(1, 65), res, lat);
            check("rand_latency", W'(lat), W'(LAT));
            check("rand_dout", res, l_all(a));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
